// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: serial input, FIFO read side and status of the UART receiver
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH = 4
);
  logic rx;
  logic rd_en;
  logic ovr_clr;
  logic [DATA_BITS-1:0] rx_data;
  logic rx_valid;
  logic parity_error;
  logic framing_error;
  logic overrun;
  logic break_det;
  logic [$clog2(DEPTH):0] level;
  modport slave (
    input rx, rd_en, ovr_clr,
    output rx_data, rx_valid, parity_error, framing_error, overrun, break_det, level
  );
  modport master (
    output rx, rd_en, ovr_clr,
    input rx_data, rx_valid, parity_error, framing_error, overrun, break_det, level
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: majority-voting UART receiver feeding a small frame FIFO with sticky overrun/break flags
module uart_rx_fifo #(
  parameter int DIVISOR = 5208,
  parameter int DATA_BITS = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS = 1,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic nrst,
  uart_rx_fifo_if.slave bus
);
  localparam int CW = $clog2(DIVISOR);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] C_M0 = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] C_M1 = CW'(DIVISOR / 2);
  localparam logic [CW-1:0] C_M2 = CW'(DIVISOR / 2 + 1);
  localparam logic [CW-1:0] C_END = CW'(DIVISOR - 1);
  localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic rx_s, rx_q, fall;
  logic [CW-1:0] cnt;
  logic [3:0] bidx;
  logic [1:0] smp;
  logic [DATA_BITS-1:0] data;
  logic par_bit, fr;
  logic mid, bit_end, maj, push, fr_fin, par_err, brk;
  logic [DATA_BITS+1:0] mem [DEPTH];
  logic [DATA_BITS+1:0] head;
  logic [AW-1:0] wp, rp;
  logic [AW:0] lvl;
  logic full, pop, wr, ovr_set, ovr, brk_det;
  assign rx_s = sync[1];
  assign fall = rx_q & ~rx_s;
  always_comb begin
    mid = cnt == C_M2;
    bit_end = cnt == C_END;
    maj = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
    push = state == STOP && mid && bidx == LAST_S;
    fr_fin = fr | ~maj;
    par_err = PARITY_MODE == 0 ? 1'b0 : (^data ^ par_bit) ^ (PARITY_MODE == 2);
    brk = fr_fin && data == '0 && (PARITY_MODE == 0 || !par_bit);
    full = lvl == (AW + 1)'(DEPTH);
    pop = bus.rd_en && lvl != '0;
    wr = push && (!full || pop);
    ovr_set = push && full && !pop;
    state_n = state;
    case (state)
      IDLE: state_n = fall ? START : IDLE;
      START: state_n = mid && maj ? IDLE : bit_end ? DATA : START;
      DATA: state_n = bit_end && bidx == LAST_D ? (PARITY_MODE != 0 ? PARITY : STOP) : DATA;
      PARITY: state_n = bit_end ? STOP : PARITY;
      STOP: state_n = push ? (maj ? IDLE : WAIT_HIGH) : STOP;
      WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (nrst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (nrst) begin
      sync <= 2'b11;
      rx_q <= 1'b1;
      cnt <= '0;
      bidx <= '0;
      smp <= '0;
      data <= '0;
      par_bit <= 1'b0;
      fr <= 1'b0;
      wp <= '0;
      rp <= '0;
      lvl <= '0;
      ovr <= 1'b0;
      brk_det <= 1'b0;
    end else begin
      sync <= {sync[0], bus.rx};
      rx_q <= rx_s;
      cnt <= (state == IDLE || state_n != state || bit_end) ? '0 : cnt + 1'b1;
      bidx <= state_n != state ? '0 : bit_end ? bidx + 1'b1 : bidx;
      if (cnt == C_M0) smp[0] <= rx_s;
      if (cnt == C_M1) smp[1] <= rx_s;
      if (state == DATA && mid) data <= {maj, data[DATA_BITS-1:1]};
      if (state == PARITY && mid) par_bit <= maj;
      if (state == IDLE) fr <= 1'b0;
      else if (state == STOP && mid && !maj) fr <= 1'b1;
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      lvl <= lvl + (AW + 1)'(wr) - (AW + 1)'(pop);
      ovr <= ovr_set | (ovr & ~bus.ovr_clr);
      brk_det <= (push & brk) | (brk_det & ~bus.ovr_clr);
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= {fr_fin, par_err, data};
  assign head = lvl != '0 ? mem[rp] : '0;
  assign {bus.framing_error, bus.parity_error, bus.rx_data} = head;
  assign bus.rx_valid = lvl != '0;
  assign bus.level = lvl;
  assign bus.overrun = ovr;
  assign bus.break_det = brk_det;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized 8E1 frames checked against a queue-based model
module tb_uart_rx_fifo;
  localparam int DIV = 16;
  logic clk = 1'b0;
  logic nrst;
  int checks = 0;
  int errors = 0;
  logic [9:0] q[$];
  logic ovr_m = 1'b0;
  logic brk_m = 1'b0;
  uart_rx_fifo_if #(.DATA_BITS(8), .DEPTH(4)) bus ();
  uart_rx_fifo #(.DIVISOR(DIV), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .DEPTH(4)) dut (
    .clk(clk),
    .nrst(nrst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_push(input logic [7:0] d, input logic p, input logic st);
    if (d == 8'h00 && !p && !st) brk_m = 1'b1;
    if (q.size() < 4) q.push_back({~st, ^d ^ p, d});
    else ovr_m = 1'b1;
  endtask
  task automatic check_all(input string tag);
    logic [9:0] h;
    h = q.size() != 0 ? q[0] : 10'h0;
    check({tag, ".level"}, 32'(bus.level), 32'(q.size()));
    check({tag, ".valid"}, 32'(bus.rx_valid), 32'(q.size() != 0));
    check({tag, ".data"}, 32'(bus.rx_data), 32'(h[7:0]));
    check({tag, ".perr"}, 32'(bus.parity_error), 32'(h[8]));
    check({tag, ".ferr"}, 32'(bus.framing_error), 32'(h[9]));
    check({tag, ".ovr"}, 32'(bus.overrun), 32'(ovr_m));
    check({tag, ".brk"}, 32'(bus.break_det), 32'(brk_m));
  endtask
  task automatic send(input logic [7:0] d, input logic p, input logic st);
    bus.rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      tick(DIV);
    end
    bus.rx = p;
    tick(DIV);
    bus.rx = st;
    tick(DIV);
    bus.rx = 1'b1;
    tick(2 * DIV);
    model_push(d, p, st);
  endtask
  task automatic pop();
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask
  task automatic clr();
    bus.ovr_clr = 1'b1;
    tick(1);
    bus.ovr_clr = 1'b0;
    ovr_m = 1'b0;
    brk_m = 1'b0;
  endtask
  initial begin
    logic [7:0] d;
    logic p, st;
    nrst = 1'b1;
    bus.rx = 1'b1;
    bus.rd_en = 1'b0;
    bus.ovr_clr = 1'b0;
    tick(4);
    check_all("reset");
    nrst = 1'b0;
    tick(4);
    send(8'hA5, 1'b0, 1'b1);
    check_all("a5");
    pop();
    check_all("a5_pop");
    send(8'h01, 1'b0, 1'b1);
    check_all("perr");
    pop();
    check_all("perr_pop");
    pop();
    check_all("empty_pop");
    bus.rx = 1'b0;
    tick(5);
    bus.rx = 1'b1;
    tick(3 * DIV);
    check_all("glitch");
    bus.rx = 1'b0;
    tick(3 * 11 * DIV);
    bus.rx = 1'b1;
    tick(2 * DIV);
    model_push(8'h00, 1'b0, 1'b0);
    check_all("break");
    tick(4 * DIV);
    check_all("break_once");
    pop();
    clr();
    check_all("break_clr");
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      send(d, ^d, 1'b1);
    end
    check_all("full");
    for (int i = 0; i < 4; i++) begin
      pop();
      check_all("drain");
    end
    clr();
    check_all("ovr_clr");
    bus.rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 3; i++) begin
      bus.rx = i[0];
      tick(DIV);
    end
    tick(DIV / 2);
    nrst = 1'b1;
    tick(1);
    nrst = 1'b0;
    bus.rx = 1'b1;
    q.delete();
    ovr_m = 1'b0;
    brk_m = 1'b0;
    tick(12 * DIV);
    check_all("mid_reset");
    send(8'h3C, 1'b0, 1'b1);
    check_all("after_reset");
    pop();
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      if ($urandom % 8 == 0) d = 8'h00;
      p = ^d ^ ($urandom % 4 == 0);
      st = $urandom % 6 != 0;
      send(d, p, st);
      check_all("rand");
      repeat ($urandom % 3) begin
        pop();
        check_all("rand_pop");
      end
      if ($urandom % 5 == 0) begin
        clr();
        check_all("rand_clr");
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DIVISOR, 5208, clk cycles per bit period; SHALL be >= 8.
REQ-002 Parameter DATA_BITS, 8, data bits per frame; SHALL be 5 to 9.
REQ-003 Parameter PARITY_MODE, 1, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, 1, stop bits checked per frame; SHALL be 1 or 2.
REQ-005 Parameter DEPTH, 4, receive FIFO entries; SHALL be a power of two, >= 2.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 nrst  input  1  reset, synchronous, active-high.
REQ-008 rx  input  1  asynchronous serial line, idle high.
REQ-009 rd_en  input  1  pop FIFO head when rx_valid=1.
REQ-010 ovr_clr  input  1  clear overrun and break flags.
REQ-011 rx_data  output  DATA_BITS  head-entry data, LSB = first received bit.
REQ-012 rx_valid  output  1  FIFO not empty.
REQ-013 parity_error  output  1  head-entry parity mismatch (0 when PARITY_MODE=0).
REQ-014 framing_error  output  1  head-entry stop-bit error.
REQ-015 overrun  output  1  sticky; frame dropped because FIFO full.
REQ-016 break_det  output  1  sticky; break condition received.
REQ-017 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 rx SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized signal.
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-020 Bit counter runs 0..DIVISOR-1 and restarts at 0 on entry to each bit; the bit value is the 2-of-3 majority of samples at counts M-1, M, M+1, where M = DIVISOR/2 (floor).
REQ-021 IDLE -> START on a synchronized 1-to-0 transition; the counter is cleared in that cycle.
REQ-022 START: a majority value of 1 returns the FSM to IDLE with no flag and no push (glitch rejection); otherwise the FSM enters DATA at count DIVISOR-1.
REQ-023 DATA: shifts DATA_BITS bits LSB-first, then goes to PARITY if PARITY_MODE != 0, else to STOP.
REQ-024 PARITY: error = (XOR of data bits XOR parity bit) != 0 for even, == 0 for odd.
REQ-025 STOP: each stop-bit majority of 0 sets the frame's framing bit; after the majority of the last stop bit is resolved, the frame SHALL be pushed in the same cycle without waiting for the bit end.
REQ-026 After the push, the FSM goes to IDLE if the last stop bit is 1, else to WAIT_HIGH; WAIT_HIGH exits to IDLE only on synchronized rx=1.
REQ-027 Break: all data bits 0, parity bit 0 if present, and framing error SHALL set break_det; the frame is still pushed with framing_error=1.
REQ-028 Each FIFO entry stores {framing, parity, data}; rx_data, parity_error and framing_error SHALL reflect the head entry and read 0 when the FIFO is empty.
REQ-029 Pushed data SHALL be visible on the outputs in the cycle after the push cycle.
REQ-030 rd_en while the FIFO is empty SHALL be ignored, with no pointer change.
REQ-031 Push while the FIFO is full and with no pop in the same cycle: the frame is dropped, overrun is set, and FIFO contents are unchanged.
REQ-032 Push and pop in the same cycle SHALL both succeed, including when the FIFO is full, with level unchanged.
REQ-033 ovr_clr SHALL clear overrun and break_det; a set condition in the same cycle takes priority over the clear.
REQ-034 level SHALL count 0..DEPTH without wrap; pointers wrap modulo DEPTH.

Reset
REQ-035 nrst=1 at a clock edge SHALL force: FSM IDLE, counters 0, synchronizer flops 1, FIFO empty, level 0, all outputs 0.
REQ-036 nrst asserted mid-frame SHALL abandon the frame without a push; reception resumes on the next falling edge after release.

Verification
REQ-037 DIVISOR=16, 8E1: send 0xA5 with parity 0 -> one push; rx_data=0xA5, parity_error=0, framing_error=0, level=1.
REQ-038 Send 0x01 with parity 0 under even parity -> parity_error=1 at head; rd_en pulse -> rx_valid=0, level=0.
REQ-039 rx low for 5 clks, then high (DIVISOR=16) -> FSM returns to IDLE, no push, no flags.
REQ-040 Hold rx low for 3 frame times, then release -> exactly one push with framing_error=1; break_det=1; no second frame before rx returns high.
REQ-041 DEPTH=4: send 5 frames with no reads -> level=4, overrun=1, first 4 data values preserved in order; ovr_clr -> overrun=0.
REQ-042 Assert nrst at DATA bit 3, release, then send 0x3C -> only 0x3C is received, level=1.
